// File: rtl/adder_mul_seq.sv
// Sequential unsigned shift-and-add multiplier controller.
// Drives an external shared 16-bit adder one partial product per clock.
module adder_mul_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  output logic               add_ci,
  input  logic [15:0]        add_s,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned AW = 16;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    add_a_q, add_a_d;
  logic [AW-1:0]    add_b_q, add_b_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates and registered outputs; adder inputs are quiet outside RUN
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = AW'(op_a);
          mplier_d = op_b;
          count_d  = '0;
        end
      end
      S_RUN: begin
        acc_d    = add_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
      end
      S_DONE:  product_d = acc_q[PW-1:0];
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    add_a_d = (state_d == S_RUN) ? acc_d : '0;
    add_b_d = ((state_d == S_RUN) && mplier_d[0]) ? mcand_d : '0;
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_ci  = 1'b0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_adder_mul_seq.sv
// Directed self-checking bench for adder_mul_seq with a behavioural shared adder.
module tb_adder_mul_seq;

  localparam int unsigned WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic [15:0] add_a, add_b, add_s;
  logic        add_ci;
  logic        busy, done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int done_cyc = 0;

  adder_mul_seq #(.WIDTH(WIDTH), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s),
    .busy(busy), .done(done), .product(product)
  );

  // Shared 16-bit ripple adder, carry out discarded
  assign add_s = add_a + add_b + {15'd0, add_ci};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Issue one multiply from IDLE and check every RUN step, DONE cycle and result
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    logic [15:0] exp_acc;
    logic [15:0] exp_b;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    cyc();
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    exp_acc = 16'h0000;
    for (int k = 0; k < int'(WIDTH); k++) begin
      exp_b = b[k] ? (16'(a) << k) : 16'h0000;
      check("run_add_a", add_a, exp_acc);
      check("run_add_b", add_b, exp_b);
      check("run_busy", 16'(busy), 16'd1);
      check("run_done", 16'(done), 16'd0);
      exp_acc = exp_acc + exp_b;
      cyc();
    end
    check("done_pulse", 16'(done), 16'd1);
    check("done_busy", 16'(busy), 16'd1);
    check("done_add_a", add_a, 16'h0000);
    check("done_add_b", add_b, 16'h0000);
    done_cyc = cyc_cnt;
    cyc();
    check("idle_done", 16'(done), 16'd0);
    check("idle_busy", 16'(busy), 16'd0);
    check("product", product, p);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];
  int   d1;
  int   ndone;

  initial begin
    vecs[0] = '{a: 8'h0F, b: 8'h11, p: 16'h00FF};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'hA5, p: 16'h0000};
    vecs[3] = '{a: 8'h5A, b: 8'h00, p: 16'h0000};
    vecs[4] = '{a: 8'h03, b: 8'h05, p: 16'h000F};
    vecs[5] = '{a: 8'h07, b: 8'h09, p: 16'h003F};
    vecs[6] = '{a: 8'hC8, b: 8'h02, p: 16'h0190};
    vecs[7] = '{a: 8'h80, b: 8'h80, p: 16'h4000};
    vecs[8] = '{a: 8'h01, b: 8'hFF, p: 16'h00FF};
    vecs[9] = '{a: 8'hAA, b: 8'h55, p: 16'h3872};

    rst = 1'b1; start = 1'b0; op_a = 8'h00; op_b = 8'h00;
    cyc(); cyc();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_product", product, 16'h0000);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);
    check("rst_add_ci", 16'(add_ci), 16'd0);

    // Reset wins over a simultaneous start
    start = 1'b1; op_a = 8'h12; op_b = 8'h34;
    cyc();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 16'(busy), 16'd0);
    cyc();
    check("rst_start_idle", 16'(busy), 16'd0);

    for (int i = 0; i < 10; i++) run_mul(vecs[i].a, vecs[i].b, vecs[i].p);

    // Starts during RUN cycle 4 and during DONE are ignored
    op_a = 8'h03; op_b = 8'h05; start = 1'b1;
    cyc();
    ndone = 0;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      start = (i == 4);
      op_a  = (i == 4) ? 8'h77 : 8'h03;
      op_b  = (i == 4) ? 8'h77 : 8'h05;
      if (done) ndone++;
      cyc();
    end
    start = 1'b0;
    check("ign_run_done_cnt", 16'(ndone), 16'd0);
    check("ign_done_pulse", 16'(done), 16'd1);
    op_a = 8'h77; op_b = 8'h77; start = 1'b1;
    cyc();
    start = 1'b0;
    check("ign_idle_done", 16'(done), 16'd0);
    check("ign_idle_busy", 16'(busy), 16'd0);
    check("ign_product", product, 16'h000F);
    cyc();
    check("ign_stay_idle", 16'(busy), 16'd0);
    check("ign_no_done", 16'(done), 16'd0);
    check("ign_add_b", add_b, 16'h0000);

    // Reset mid-run aborts the multiply
    op_a = 8'hC8; op_b = 8'h02; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_product", product, 16'h0000);
    check("abort_add_a", add_a, 16'h0000);
    check("abort_add_b", add_b, 16'h0000);
    cyc();
    check("abort_no_done", 16'(done), 16'd0);
    run_mul(8'h07, 8'h09, 16'h003F);

    // Back-to-back: second start in the first IDLE cycle after DONE
    run_mul(8'h03, 8'h05, 16'h000F);
    d1 = done_cyc;
    run_mul(8'h07, 8'h09, 16'h003F);
    check("b2b_spacing", 16'(done_cyc - d1), 16'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
